// File: rtl/br_csr_issue_ctrl_pkg.sv
// Types and helpers for the branch/CSR issue controller.
package br_csr_issue_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      CSR_WAIT  = 2'd1,
      CSR_ISSUE = 2'd2,
      CSR_GAP   = 2'd3
   } br_csr_state_t;

   localparam logic [1:0] CSR_UOP_PREFIX = 2'b11;

   // CSR ops are identified by the top two microop bits.
   function automatic logic is_csr_uop(input logic [4:0] uop);
      return uop[4:3] == CSR_UOP_PREFIX;
   endfunction

endpackage

// File: rtl/br_exec_pkg.sv
// Shared execution-stage payload types.
package br_exec_pkg;

   localparam int unsigned EXEC_TICKET_W = 3;

   // Operation handed from issue to a functional unit.
   typedef struct packed {
      logic                     valid;
      logic [4:0]               microop;
      logic [EXEC_TICKET_W-1:0] ticket;
      logic [4:0]               rd;
      logic [31:0]              rs1_data;
      logic [31:0]              rs2_data;
   } to_execution;

endpackage

// File: rtl/br_csr_issue_ctrl_if.sv
// Issue-side and unit-side handshake bundle for br_csr_issue_ctrl.
interface br_csr_issue_ctrl_if;

   logic                     in_valid;
   logic                     in_ready;
   br_exec_pkg::to_execution in_data;
   logic                     out_valid;
   br_exec_pkg::to_execution out_data;

   modport master (output in_valid, output in_data, input in_ready,
                   input out_valid, input out_data);
   modport slave  (input in_valid, input in_data, output in_ready,
                   output out_valid, output out_data);

endinterface

// File: rtl/br_issue_fifo.sv
// Generic DEPTH-entry queue with flush, empty/full flags and a head read port.
// Pointers carry one wrap bit above the index; head reads as zero when empty.
module br_issue_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_empty,
   output logic             o_full
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_wr_en;
   logic             w_rd_en;

   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                    (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign w_wr_en = i_push & ~o_full & ~i_flush;
   assign w_rd_en = i_pop & ~o_empty & ~i_flush;
   assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

   // Pointer update; flush empties the queue and drops any coincident push.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   // Storage write; contents are don't-care until the pointers cover them.
   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
   end

endmodule

// File: rtl/br_csr_issue_ctrl.sv
// In-order issue controller for the branch/shift/compare/CSR unit.
// Non-CSR ops go out as soon as the unit is free; CSR ops wait for their
// ticket to reach the ROB head and are followed by one bubble cycle.
// Optional perf counters: define BR_CSR_PERF_CNT_EN.
// Note: rst_n is an active-high asynchronous reset.
module br_csr_issue_ctrl
   import br_exec_pkg::*;
   import br_csr_issue_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned TICKET_W = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   br_csr_issue_ctrl_if.slave  bus,
   input  logic                flush,
   input  logic                rob_head_valid,
   input  logic [TICKET_W-1:0] rob_head_ticket,
   input  logic                fu_busy,
   output logic                csr_pending
`ifdef BR_CSR_PERF_CNT_EN
   ,
   output logic [31:0]         csr_stall_cycles,
   output logic [31:0]         full_stall_cycles
`endif
);

   localparam int unsigned DATA_W = $bits(to_execution);

   localparam logic [1:0] S_RUN       = RUN;
   localparam logic [1:0] S_CSR_WAIT  = CSR_WAIT;
   localparam logic [1:0] S_CSR_ISSUE = CSR_ISSUE;
   localparam logic [1:0] S_CSR_GAP   = CSR_GAP;

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic              w_out_valid;
   logic              w_push;
   logic              w_empty;
   logic              w_full;
   logic [DATA_W-1:0] w_head_raw;
   to_execution       w_head;
   logic              w_head_csr;
   logic              w_ticket_match;

   assign w_push = bus.in_valid & ~w_full & ~flush;

   br_issue_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst_n),
      .i_flush (flush),
      .i_push  (w_push),
      .i_wdata (bus.in_data),
      .i_pop   (w_out_valid),
      .o_rdata (w_head_raw),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   assign w_head         = to_execution'(w_head_raw);
   assign w_head_csr     = ~w_empty & is_csr_uop(w_head.microop);
   assign w_ticket_match = rob_head_valid &&
                           (rob_head_ticket == TICKET_W'(w_head.ticket));

   // State register.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) r_state <= S_RUN;
      else       r_state <= w_state_nxt;
   end

   // Next state and issue decision; flush overrides everything.
   always_comb begin
      w_state_nxt = r_state;
      w_out_valid = 1'b0;
      case (r_state)
         S_RUN: begin
            if (!w_empty) begin
               if (w_head_csr) w_state_nxt = S_CSR_WAIT;
               else            w_out_valid = ~fu_busy;
            end
         end
         S_CSR_WAIT: begin
            if (w_ticket_match) w_state_nxt = S_CSR_ISSUE;
         end
         S_CSR_ISSUE: begin
            w_out_valid = ~fu_busy;
            if (!fu_busy) w_state_nxt = S_CSR_GAP;
         end
         S_CSR_GAP: begin
            w_state_nxt = S_RUN;
         end
         default: begin
            w_state_nxt = S_RUN;
         end
      endcase
      if (flush) begin
         w_out_valid = 1'b0;
         w_state_nxt = S_RUN;
      end
   end

   assign bus.in_ready  = ~w_full;
   assign bus.out_valid = w_out_valid;
   assign bus.out_data  = w_head;
   // A CSR head stays pending until the controller is allowed to issue it.
   assign csr_pending   = w_head_csr & (r_state != S_CSR_ISSUE);

`ifdef BR_CSR_PERF_CNT_EN
   logic [31:0] r_csr_stall_cycles;
   logic [31:0] r_full_stall_cycles;

   // Saturating stall counters; flush does not clear them.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_csr_stall_cycles  <= '0;
         r_full_stall_cycles <= '0;
      end else begin
         if ((r_state == S_CSR_WAIT) && (r_csr_stall_cycles != '1))
            r_csr_stall_cycles <= r_csr_stall_cycles + 32'd1;
         if (bus.in_valid && w_full && (r_full_stall_cycles != '1))
            r_full_stall_cycles <= r_full_stall_cycles + 32'd1;
      end
   end

   assign csr_stall_cycles  = r_csr_stall_cycles;
   assign full_stall_cycles = r_full_stall_cycles;
`endif

endmodule

// File: doc/br_csr_issue_ctrl.md
Name: br_csr_issue_ctrl

Overview:
- In-order issue controller in front of the branch/shift/compare/CSR functional unit.
- Buffers up to DEPTH operations from the issue stage and forwards non-CSR ops (microop[4:3] != 2'b11) as soon as the unit is free.
- Holds every CSR op (microop 5'b11000..5'b11101) until its ticket is the ROB head, so CSR writes happen non-speculatively.
- After each CSR op, inserts one bubble so back-to-back CSR ops see the updated CSR value.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- TICKET_W, 3, ROB ticket width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  one clock; reset is asynchronous and active-high. rst_n=1 resets.
- in_valid  in  1  issue stage offers an op.
- in_ready  out  1  queue can accept; equals !full.
- in_data  in  to_execution  op payload, including microoperation, ticket, valid.
- flush  in  1  misprediction/exception flush.
- rob_head_valid  in  1  ROB head entry valid.
- rob_head_ticket  in  TICKET_W  ticket at ROB head.
- fu_busy  in  1  unit busy, from busy_fu.
- out_valid  out  1  drives the unit's valid.
- out_data  out  to_execution  payload to the unit.
- csr_pending  out  1  head is a CSR op that is not yet issued.

Behaviour:
- Reset: queue empty, rd/wr pointers 0, FSM RUN; in_ready=1, out_valid=0, csr_pending=0, out_data=0.
- Push: in_valid & in_ready & !flush writes in_data at wr_ptr. Pointers are log2(DEPTH) bits plus a wrap bit.
  - full: pointers equal, wrap bits differ.
  - empty: pointers and wrap bits both equal.
- Minimum latency: push in cycle N, out_valid in cycle N+1. There is no bypass.
- Pop: happens when out_valid & !fu_busy. Push and pop in the same cycle while full is not allowed, because in_ready=0 when full.
- FSM (registered state):
  - RUN:
    - Head non-CSR and !fu_busy: out_valid=1, pop.
    - Head CSR: go to CSR_WAIT with out_valid=0 in that cycle.
  - CSR_WAIT:
    - csr_pending=1, out_valid=0.
    - When rob_head_valid and rob_head_ticket == head ticket, go to CSR_ISSUE.
  - CSR_ISSUE:
    - out_valid = !fu_busy. On pop, go to CSR_GAP. Otherwise stay.
  - CSR_GAP:
    - out_valid=0 for exactly one cycle, then RUN.
- out_data is the head entry, combinational from the queue. It is zero when the queue is empty.
- Flush, same cycle:
  - Queue emptied, FSM returns to RUN.
  - A coincident push is discarded.
  - out_valid is forced to 0 in the flush cycle.
- Flush during CSR_ISSUE with fu_busy=0: flush has priority and no issue occurs.
- Ticket compare is exact on TICKET_W bits; ticket wrap needs no special handling.
- Async reset asserted mid-operation clears everything immediately, with no pending output.

Optional Feature:
- Macro BR_CSR_PERF_CNT_EN.
- When defined, add two outputs, each 32-bit and saturating at 32'hFFFF_FFFF:
  - csr_stall_cycles: counts cycles in CSR_WAIT.
  - full_stall_cycles: counts cycles with in_valid & !in_ready.
- Both counters reset to 0 and are not cleared by flush.
- When not defined, neither the ports nor the logic exist.

Decomposition:
- Shared package gets:
  - br_csr_state_t enum (RUN, CSR_WAIT, CSR_ISSUE, CSR_GAP).
  - CSR_UOP_PREFIX = 2'b11 constant.
  - is_csr_uop() helper function.
- to_execution stays in the existing struct package.
- One sub-module, br_issue_fifo: a generic DEPTH-entry queue with flush, empty/full flags and a head read port.

Test Plan:
- Three SLT ops (uop 5'b00000) pushed back-to-back, fu_busy=0 → out_valid in cycles 1,2,3, in order; in_ready stays 1.
- CSR op (uop 5'b11000, ticket 5) at head, rob_head_ticket=3 for 4 cycles then 5 → csr_pending=1 and out_valid=0 for 5 cycles; issue the cycle after the match; one gap cycle follows.
- Two CSR ops, tickets 2 and 3, with the ROB head advancing immediately → issues separated by at least one bubble (the CSR_GAP cycle) plus the CSR_WAIT cycle.
- DEPTH=4, four pushes with fu_busy=1 → in_ready=0 after the fourth; fifth push held; after fu_busy=0, one pop per cycle and in_ready=1 next cycle.
- Flush asserted together with a push while in CSR_WAIT → queue empty next cycle, FSM in RUN, pushed op never appears.
- With BR_CSR_PERF_CNT_EN defined, a CSR waits 7 cycles → csr_stall_cycles=7; a second run from reset checks saturation by forcing the counter to 32'hFFFF_FFFE.
